// File: rtl/imm_extend_pipe_pkg.sv
// mips_defs: shared extension-mode encodings and default datapath widths.
package mips_defs;

   localparam int IMM_W  = 16;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      EXT_SIGN   = 2'b00,
      EXT_ZERO   = 2'b01,
      EXT_UPPER  = 2'b10,
      EXT_BRANCH = 2'b11
   } ext_mode_e;

endpackage

// File: rtl/imm_extend_core.sv
// imm_extend_core: combinational immediate extender (sign, zero, upper, branch offset).
module imm_extend_core
   import mips_defs::*;
#(
   parameter int IN_W  = IMM_W,
   parameter int OUT_W = WORD_W
) (
   input  logic [IN_W-1:0]  immediate,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] extended
);

   logic [OUT_W-1:0] sext;
   logic [OUT_W-1:0] zext;

   assign sext = {{(OUT_W-IN_W){immediate[IN_W-1]}}, immediate};
   assign zext = {{(OUT_W-IN_W){1'b0}}, immediate};

   always_comb
      extended = mode == EXT_SIGN  ? sext :
                 mode == EXT_ZERO  ? zext :
                 mode == EXT_UPPER ? zext << (OUT_W-IN_W) :
                                     sext << 2;

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: pipelined MIPS immediate extender with valid/ready handshake and flush.
// Defining IMM_EXTEND_STATS_EN adds the xfer_count and stall_seen outputs.
module imm_extend_pipe
   import mips_defs::*;
#(
   parameter int IN_W   = IMM_W,
   parameter int OUT_W  = WORD_W,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  immediate,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] extended,
   output logic [1:0]       out_mode
`ifdef IMM_EXTEND_STATS_EN
   ,
   output logic [15:0]      xfer_count,
   output logic [0:0]       stall_seen
`endif
);

   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] valid;
   logic [OUT_W-1:0]  data [STAGES];
   logic [1:0]        md   [STAGES];
   logic [OUT_W-1:0]  ext;
   logic              accept;

   imm_extend_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
      .immediate (immediate),
      .mode      (mode),
      .extended  (ext)
   );

   // Ready ripples back from the consumer: a stage may load if empty or draining.
   always_comb begin
      logic nxt;
      nxt = out_ready;
      for (int i = STAGES-1; i >= 0; i--) begin
         adv[i] = !valid[i] || nxt;
         nxt    = adv[i];
      end
   end

   assign in_ready = adv[0] && !flush;
   assign accept   = in_valid && in_ready;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic             lv;
      logic [OUT_W-1:0] ld;
      logic [1:0]       lm;
      if (s == 0) begin : g_head
         assign lv = accept;
         assign ld = ext;
         assign lm = mode;
      end else begin : g_body
         assign lv = valid[s-1];
         assign ld = data[s-1];
         assign lm = md[s-1];
      end
      // Payload only moves with a valid entry, so a flushed output keeps its last value.
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            valid[s] <= 1'b0;
            data[s]  <= '0;
            md[s]    <= '0;
         end else begin
            if (flush)
               valid[s] <= 1'b0;
            else if (adv[s])
               valid[s] <= lv;
            if (adv[s] && lv && !flush) begin
               data[s] <= ld;
               md[s]   <= lm;
            end
         end
   end

   assign out_valid = valid[STAGES-1];
   assign extended  = data[STAGES-1];
   assign out_mode  = md[STAGES-1];

`ifdef IMM_EXTEND_STATS_EN
   // A flushed output is dropped, not delivered, so it is not counted.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         xfer_count <= '0;
         stall_seen <= '0;
      end else begin
         if (out_valid && out_ready && !flush && xfer_count != 16'hFFFF)
            xfer_count <= xfer_count + 16'd1;
         if (in_valid && !in_ready)
            stall_seen <= 1'b1;
      end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed vectors plus a queue-based reference model for imm_extend_pipe.
module tb_imm_extend_pipe;

   localparam int STAGES = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] immediate = '0;
   logic [1:0]  mode = '0;
   logic [31:0] extended;
   logic [1:0]  out_mode;
`ifdef IMM_EXTEND_STATS_EN
   logic [15:0] xfer_count;
   logic [0:0]  stall_seen;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  m;
   } ent_t;
   ent_t q[$];
   int   mx = 0;
   bit   ms = 1'b0;

   always #5 clk = ~clk;

   imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(STAGES)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .immediate  (immediate),
      .mode       (mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .extended   (extended),
      .out_mode   (out_mode)
`ifdef IMM_EXTEND_STATS_EN
      ,
      .xfer_count (xfer_count),
      .stall_seen (stall_seen)
`endif
   );

   function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] md);
      int s;
      s = int'(signed'(imm));
      case (md)
         2'd0:    return 32'(s);
         2'd1:    return 32'(imm);
         2'd2:    return 32'(imm) * 32'd65536;
         default: return 32'(s * 4);
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference scoreboard: sampled mid-cycle, reflects what the next edge will do.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         mx = 0;
         ms = 1'b0;
      end else begin
`ifdef IMM_EXTEND_STATS_EN
         chk("xfer_count", 32'(xfer_count), 32'(mx));
         chk("stall_seen", 32'(stall_seen), 32'(ms));
`endif
         if (q.size() == 0)
            chk("idle_out_valid", 32'(out_valid), 32'd0);
         else if (out_valid) begin
            chk("sb_data", extended, q[0].d);
            chk("sb_mode", 32'(out_mode), 32'(q[0].m));
         end
         if (out_valid && out_ready && !flush && q.size() > 0) begin
            void'(q.pop_front());
            if (mx < 65535) mx++;
         end
         if (flush) q.delete();
         if (in_valid && in_ready) q.push_back('{d: ref_ext(immediate, mode), m: mode});
         if (in_valid && !in_ready) ms = 1'b1;
         chk("occupancy", 32'(q.size() <= STAGES), 32'd1);
      end
   end

   task automatic one(input string nm, input logic [15:0] imm, input logic [1:0] md, input logic [31:0] exp);
      chk({nm, "_model"}, ref_ext(imm, md), exp);
      immediate = imm;
      mode      = md;
      in_valid  = 1'b1;
      chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk({nm, "_lat1"}, 32'(out_valid), 32'd0);
      step();
      chk({nm, "_lat2"}, 32'(out_valid), 32'd1);
      chk(nm, extended, exp);
      chk({nm, "_mode"}, 32'(out_mode), 32'(md));
      step();
      chk({nm, "_drained"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_extended", extended, 32'd0);
      chk("rst_out_mode", 32'(out_mode), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      one("sign_pos", 16'h000A, 2'd0, 32'h0000000A);
      one("sign_neg", 16'h800A, 2'd0, 32'hFFFF800A);
      one("zero", 16'h800A, 2'd1, 32'h0000800A);
      one("upper", 16'h1234, 2'd2, 32'h12340000);
      one("branch_neg", 16'hFFFF, 2'd3, 32'hFFFFFFFC);
      one("branch_pos", 16'h0004, 2'd3, 32'h00000010);

      // Back-to-back burst at full throughput.
      for (int k = 0; k < 8; k++) begin
         immediate = 16'($urandom);
         mode      = 2'($urandom_range(0, 3));
         in_valid  = 1'b1;
         chk("burst_in_ready", 32'(in_ready), 32'd1);
         step();
      end
      in_valid = 1'b0;
      repeat (4) step();
      chk("burst_drained", 32'(q.size()), 32'd0);

      // Backpressure: fill, stall, then simultaneous deliver/accept.
      out_ready = 1'b0;
      immediate = 16'h1111; mode = 2'd0; in_valid = 1'b1;
      chk("bp_acc1", 32'(in_ready), 32'd1);
      step();
      immediate = 16'h2222; mode = 2'd1;
      chk("bp_acc2", 32'(in_ready), 32'd1);
      step();
      immediate = 16'h3333; mode = 2'd2;
      chk("bp_full", 32'(in_ready), 32'd0);
      step();
      chk("bp_still_full", 32'(in_ready), 32'd0);
      chk("bp_head", extended, 32'h00001111);
      step();
      chk("bp_hold", extended, 32'h00001111);
      out_ready = 1'b1;
      #1;
      chk("bp_ready_same_cycle", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("bp_second", extended, 32'h00002222);
      chk("bp_second_mode", 32'(out_mode), 32'd1);
      step();
      chk("bp_third", extended, 32'h33330000);
      step();
      chk("bp_empty", 32'(out_valid), 32'd0);

      // Flush a full pipeline while a new entry is offered.
      out_ready = 1'b0;
      immediate = 16'h0001; mode = 2'd0; in_valid = 1'b1;
      step();
      immediate = 16'h0002;
      step();
      immediate = 16'h0003; flush = 1'b1;
      #1;
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_ext_kept", extended, 32'h00000001);
      out_ready = 1'b1;
      immediate = 16'h0004; mode = 2'd3; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("post_flush_lat1", 32'(out_valid), 32'd0);
      step();
      chk("post_flush_lat2", 32'(out_valid), 32'd1);
      chk("post_flush_data", extended, 32'h00000010);
      step();

      // Asynchronous reset with two entries held.
      out_ready = 1'b0;
      immediate = 16'h00AA; mode = 2'd0; in_valid = 1'b1;
      step();
      immediate = 16'h00BB;
      step();
      in_valid = 1'b0;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_data", extended, 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("no_stale", 32'(out_valid), 32'd0);
      end

      // Five transfers, then one stalled push, then a flush.
      for (int k = 0; k < 5; k++)
         one("stat_xfer", 16'(k * 3 + 1), 2'd1, 32'(k * 3 + 1));
      out_ready = 1'b0;
      immediate = 16'h0055; mode = 2'd0; in_valid = 1'b1;
      step();
      step();
      chk("stall_blocked", 32'(in_ready), 32'd0);
      step();
      in_valid = 1'b0;
`ifdef IMM_EXTEND_STATS_EN
      chk("stat_count5", 32'(xfer_count), 32'd5);
      chk("stat_stall", 32'(stall_seen), 32'd1);
`endif
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("stat_flush_valid", 32'(out_valid), 32'd0);
`ifdef IMM_EXTEND_STATS_EN
      chk("stat_count_kept", 32'(xfer_count), 32'd5);
`endif
      step();
      chk("final_queue_empty", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
